mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register. It does the following:
- consumes the EX/MEM register outputs;
- performs loads and stores over a request/acknowledge data-memory port, stalling upstream until the memory acknowledges;
- resolves branch/jump redirection;
- owns the MEM/WB pipeline register feeding write-back.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: reset value of `wb_pc`.

Ports:
- `clock`, in, 1: rising-edge clock. Single clock domain.
- `resetn`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: EX/MEM holds a real instruction (0 = bubble).
- `i_ir`, `i_pc`, in, 32 each: instruction and its PC.
- `i_aluout`, in, 32: ALU result; effective byte address for loads and stores.
- `i_b`, in, 32: store data.
- `i_regdest`, in, 5: write-back register.
- `i_regwrite`, `i_memread`, `i_memwrite`, `i_memtoreg`, `i_branchs`, `i_jumps`, `i_zero`, in, 1 each: control and flags.
- `i_branch`, `i_jump`, in, 32 each: branch and jump targets.
- `dm_req`, out, 1: memory request.
- `dm_we`, out, 1: 1 = write.
- `dm_addr`, out, 32: word-aligned address ({i_aluout[31:2],2'b00}).
- `dm_wdata`, out, 32: write data.
- `dm_be`, out, 4: byte enables.
- `dm_ack`, in, 1: memory completes the request this cycle.
- `dm_rdata`, in, 32: read data, valid with `dm_ack`.
- `stall`, out, 1: hold EX/MEM and earlier stages (drives the EX/MEM enable low).
- `redirect`, out, 1: take `pc_target` and flush younger stages.
- `pc_target`, out, 32: redirect target.
- `mem_err`, out, 1: one-cycle pulse on a misaligned access.
- `wb_valid`, `wb_regwrite`, `wb_memtoreg`, out, 1 each: MEM/WB control.
- `wb_regdest`, out, 5: MEM/WB destination register.
- `wb_aluout`, `wb_memdata`, `wb_pc`, `wb_ir`, out, 32 each: MEM/WB data.

## Operation
State machine has two states, S_IDLE and S_ACCESS.
- **Memory op:** `is_mem` = `in_valid` & (`i_memread` | `i_memwrite`).
- **S_IDLE, aligned `is_mem`:**
  - `stall`=1, next state S_ACCESS.
  - MEM/WB loads a bubble (`wb_valid`=0, `wb_regwrite`=0).
- **S_IDLE, non-memory instruction or bubble:** MEM/WB loads the inputs at the next edge; `wb_valid` = `in_valid`; `wb_memdata` = 0.
- **S_ACCESS:**
  - `dm_req`=1; `dm_we` = `i_memwrite`.
  - `dm_addr`, `dm_wdata` and `dm_be` are driven combinationally from the inputs, which stay stable because upstream is stalled.
  - `stall` = ~`dm_ack`.
  - On `dm_ack`: MEM/WB loads the instruction, `wb_memdata` = aligned/extended `dm_rdata` (0 for stores), next state S_IDLE.
- **Misaligned access:**
  - No request and no stall.
  - `mem_err` pulses on the next cycle.
  - MEM/WB loads the instruction with `wb_regwrite` forced to 0 and `wb_valid`=1.
- **Redirect:**
  - `redirect` = `in_valid` & ((`i_branchs` & `i_zero`) | `i_jumps`), combinational.
  - `pc_target` = `i_jumps` ? `i_jump` : `i_branch` (jump wins).
  - `redirect` is never asserted together with `stall`, since branch and jump instructions are not memory ops.
- **Outputs outside S_ACCESS:** `dm_req`, `dm_we` and `dm_be` are 0.

## Timing
- **Non-memory instruction:** 1 cycle from EX/MEM to MEM/WB.
- **Memory op:** 1 + N cycles, where N ≥ 1 is the number of S_ACCESS cycles up to and including `dm_ack`. Minimum 2 cycles; back-to-back memory ops each take ≥ 2 cycles.
- **`dm_ack` outside S_ACCESS:** ignored.
- **`dm_ack` with `dm_req` not asserted:** ignored.
- **Reset, at any time including mid-access:**
  - State goes to S_IDLE immediately; `dm_req`=0 immediately.
  - A late `dm_ack` is ignored.
- **Reset values:**
  - All `wb_*` = 0, except `wb_pc` = `RESET_PC`.
  - `mem_err`=0.
  - `stall`, `redirect` and `dm_*` follow their combinational definitions; the bench holds `in_valid`=0 during reset.

## Configuration
Macro `DMEM_SUBWORD_EN` selects sub-word load/store support.

Defined:
- Opcode `i_ir[31:26]` selects the access: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
- Byte accesses: `dm_be` is the one-hot byte lane given by `addr[1:0]`; store data is replicated into the selected lane.
- Halfword accesses: `dm_be` is 4'b0011 or 4'b1100; misaligned if `addr[0]`=1.
- Loads shift the selected lane to the low bits and sign- or zero-extend it.
- Word accesses: misaligned if `addr[1:0]`≠0.

Not defined:
- Every memory op is a word access with `dm_be`=4'hF.
- Misaligned if `addr[1:0]`≠0.
- The opcode is not decoded.

## Structure
- **Shared package `mips_pkg`:** opcode constants, the state enum (S_IDLE, S_ACCESS), and access-size encoding (BYTE/HALF/WORD).
- **Sub-module `load_align`:** combinational; inputs `dm_rdata`, `addr[1:0]`, size and signed flag; output is the 32-bit write-back value. Instantiated only when `DMEM_SUBWORD_EN` is defined.

## Test plan
- **Reset mid-access:** memory never acks and `resetn` is pulsed low. Required: `dm_req` falls immediately; state returns to S_IDLE; `wb_*` = 0; a late ack produces no write-back.
- **Word load:** lw to 0x100, memory acks after 3 cycles with 0xDEADBEEF. Required: `stall` high for 3 cycles; `wb_memdata`=0xDEADBEEF; `wb_regwrite`=1; total latency 4 cycles.
- **Store with same-cycle ack:** sw to 0x104 with `i_b`=0x12345678. Required: `dm_we`=1, `dm_be`=4'hF, `dm_addr`=0x104, `dm_wdata`=0x12345678; MEM/WB valid 2 cycles after entry.
- **Misaligned:** lw to 0x102. Required: no `dm_req`; `mem_err` pulses once; `wb_regwrite`=0.
- **Branch and jump:** `i_branchs`=1, `i_zero`=1, `i_branch`=0x40 gives `redirect`=1 and `pc_target`=0x40 in the same cycle. Adding `i_jumps`=1 with `i_jump`=0x80 gives `pc_target`=0x80.
- **Sub-word (with `DMEM_SUBWORD_EN`):** lb at 0x203 with `dm_rdata`=0x80FF_FF7F gives `dm_be`=4'b1000 and `wb_memdata`=0xFFFF_FF80. lbu at the same address gives 0x0000_0080.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: opcodes, FSM states, access sizes
// and the MEM/WB register layout.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} memState_t;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} accSize_t;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  regdest;
    logic [31:0] aluout;
    logic [31:0] memdata;
    logic [31:0] pc;
    logic [31:0] ir;
  } memWb_t;

  function automatic accSize_t opSize(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return BYTE;
      OP_LH, OP_LHU, OP_SH: return HALF;
      default:              return WORD;
    endcase
  endfunction

  function automatic logic opSigned(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the addressed byte/halfword of a memory word down to bit 0 and
// sign- or zero-extends it for write-back.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] dm_rdata,
  input  logic [1:0]  addr,
  input  accSize_t    size,
  input  logic        isSigned,
  output logic [31:0] wbData
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = dm_rdata[{addr, 3'b000} +: 8];
    laneHalf = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size)
      BYTE:    wbData = {{24{isSigned & laneByte[7]}}, laneByte};
      HALF:    wbData = {{16{isSigned & laneHalf[15]}}, laneHalf};
      default: wbData = dm_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: request/ack data-memory port, branch/jump redirect, MEM/WB register.
// Define DMEM_SUBWORD_EN for byte/halfword loads and stores (opcode decoded).
module mem_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] i_ir,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_aluout,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_regdest,
  input  logic        i_regwrite,
  input  logic        i_memread,
  input  logic        i_memwrite,
  input  logic        i_memtoreg,
  input  logic        i_branchs,
  input  logic        i_jumps,
  input  logic        i_zero,
  input  logic [31:0] i_branch,
  input  logic [31:0] i_jump,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] pc_target,
  output logic        mem_err,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic [4:0]  wb_regdest,
  output logic [31:0] wb_aluout,
  output logic [31:0] wb_memdata,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_ir
);

  memState_t   state, nextState;
  memWb_t      wbQ, wbD;
  logic        isMem, misaligned, memErrD;
  logic [1:0]  addrLo;
  logic [3:0]  beMask;
  logic [31:0] wdataLane, loadData;

  assign isMem  = in_valid & (i_memread | i_memwrite);
  assign addrLo = i_aluout[1:0];

`ifdef DMEM_SUBWORD_EN
  accSize_t accSz;
  logic     accSigned;

  assign accSz     = opSize(i_ir[31:26]);
  assign accSigned = opSigned(i_ir[31:26]);

  // Store data is replicated so the addressed lane carries it whatever the offset.
  always_comb begin
    beMask     = 4'hF;
    wdataLane  = i_b;
    misaligned = |addrLo;
    case (accSz)
      BYTE: begin
        beMask     = 4'b0001 << addrLo;
        wdataLane  = {4{i_b[7:0]}};
        misaligned = 1'b0;
      end
      HALF: begin
        beMask     = addrLo[1] ? 4'b1100 : 4'b0011;
        wdataLane  = {2{i_b[15:0]}};
        misaligned = addrLo[0];
      end
      default: ;
    endcase
  end

  load_align uLoadAlign (
    .dm_rdata (dm_rdata),
    .addr     (addrLo),
    .size     (accSz),
    .isSigned (accSigned),
    .wbData   (loadData)
  );
`else
  assign beMask     = 4'hF;
  assign wdataLane  = i_b;
  assign misaligned = |addrLo;
  assign loadData   = dm_rdata;
`endif

  assign dm_addr   = {i_aluout[31:2], 2'b00};
  assign dm_wdata  = wdataLane;
  assign redirect  = in_valid & ((i_branchs & i_zero) | i_jumps);
  assign pc_target = i_jumps ? i_jump : i_branch;

  always_comb begin
    nextState   = state;
    memErrD     = 1'b0;
    stall       = 1'b0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    dm_be       = 4'h0;
    wbD.valid    = in_valid;
    wbD.regwrite = i_regwrite;
    wbD.memtoreg = i_memtoreg;
    wbD.regdest  = i_regdest;
    wbD.aluout   = i_aluout;
    wbD.memdata  = '0;
    wbD.pc       = i_pc;
    wbD.ir       = i_ir;
    case (state)
      S_IDLE: begin
        if (isMem && misaligned) begin
          memErrD      = 1'b1;
          wbD.valid    = 1'b1;
          wbD.regwrite = 1'b0;
        end else if (isMem) begin
          stall        = 1'b1;
          nextState    = S_ACCESS;
          wbD.valid    = 1'b0;
          wbD.regwrite = 1'b0;
        end
      end
      S_ACCESS: begin
        dm_req = 1'b1;
        dm_we  = i_memwrite;
        dm_be  = beMask;
        stall  = ~dm_ack;
        if (dm_ack) begin
          nextState = S_IDLE;
          if (i_memread && !i_memwrite) wbD.memdata = loadData;
        end else begin
          // Keep write-back quiet while waiting so nothing retires twice.
          wbD.valid    = 1'b0;
          wbD.regwrite = 1'b0;
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      mem_err <= 1'b0;
      wbQ     <= '0;
      wbQ.pc  <= RESET_PC;
    end else begin
      state   <= nextState;
      mem_err <= memErrD;
      wbQ     <= wbD;
    end
  end

  assign wb_valid    = wbQ.valid;
  assign wb_regwrite = wbQ.regwrite;
  assign wb_memtoreg = wbQ.memtoreg;
  assign wb_regdest  = wbQ.regdest;
  assign wb_aluout   = wbQ.aluout;
  assign wb_memdata  = wbQ.memdata;
  assign wb_pc       = wbQ.pc;
  assign wb_ir       = wbQ.ir;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs, a monitor
// pops and compares them (including retire cycle) whenever wb_valid is seen.
module tb_mem_stage;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] i_ir, i_pc, i_aluout, i_b, i_branch, i_jump;
  logic [4:0]  i_regdest;
  logic        i_regwrite, i_memread, i_memwrite, i_memtoreg, i_branchs, i_jumps, i_zero;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        stall, redirect, mem_err;
  logic [31:0] pc_target;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_regdest;
  logic [31:0] wb_aluout, wb_memdata, wb_pc, wb_ir;

  mem_stage #(.RESET_PC(RPC)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid),
    .i_ir(i_ir), .i_pc(i_pc), .i_aluout(i_aluout), .i_b(i_b),
    .i_regdest(i_regdest), .i_regwrite(i_regwrite), .i_memread(i_memread),
    .i_memwrite(i_memwrite), .i_memtoreg(i_memtoreg), .i_branchs(i_branchs),
    .i_jumps(i_jumps), .i_zero(i_zero), .i_branch(i_branch), .i_jump(i_jump),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall), .redirect(redirect), .pc_target(pc_target), .mem_err(mem_err),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_regdest(wb_regdest), .wb_aluout(wb_aluout), .wb_memdata(wb_memdata),
    .wb_pc(wb_pc), .wb_ir(wb_ir)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        regwrite, memtoreg, memErr;
    logic [4:0]  regdest;
    logic [31:0] aluout, memdata, pc, ir;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    bit          rd, wr, br, zr, jp;
    logic [31:0] addr, bdat, rdat, brT, jpT;
    int          nAck;
  } stim_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: access width in bytes and signedness from the opcode.
  function automatic void accInfo(input logic [5:0] op, output int bytes, output bit sgn);
    bytes = 4;
    sgn   = 1'b0;
`ifdef DMEM_SUBWORD_EN
    case (op)
      6'h20: begin bytes = 1; sgn = 1'b1; end
      6'h24, 6'h28: bytes = 1;
      6'h21: begin bytes = 2; sgn = 1'b1; end
      6'h25, 6'h29: bytes = 2;
      default: bytes = 4;
    endcase
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] w, input int off, input int bytes, input bit sgn);
    logic [31:0] v, span;
    if (bytes == 4) return w;
    span = 32'd1 << (8 * bytes);
    v = (w >> (8 * off)) % span;
    if (sgn && v >= span / 2) v = v - span;
    return v;
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] b, input int bytes);
    if (bytes == 1) return (b % 256) * 32'h0101_0101;
    if (bytes == 2) return (b % 65536) * 32'h0001_0001;
    return b;
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s.op = 6'h00; s.rd = 0; s.wr = 0; s.br = 0; s.zr = 0; s.jp = 0;
    s.addr = '0; s.bdat = '0; s.rdat = '0; s.brT = '0; s.jpT = '0; s.nAck = 1;
    return s;
  endfunction

  // Called just after a rising edge; returns just after the edge that retires the instruction.
  task automatic doInstr(input stim_t s);
    exp_t e;
    int bytes, off;
    bit sgn, isMem, mis;
    logic [3:0] expBe;
    accInfo(s.op, bytes, sgn);
    off   = int'(s.addr % 4);
    isMem = s.rd || s.wr;
    mis   = isMem && (off % bytes != 0);
    expBe = 4'(((1 << bytes) - 1) << off);
    in_valid   = 1'b1;
    i_ir       = {s.op, 26'($urandom)};
    i_pc       = $urandom;
    i_aluout   = s.addr;
    i_b        = s.bdat;
    i_regdest  = 5'($urandom);
    i_regwrite = s.rd ? 1'b1 : 1'($urandom);
    i_memtoreg = 1'($urandom);
    i_memread  = s.rd;
    i_memwrite = s.wr;
    i_branchs  = s.br; i_zero = s.zr; i_jumps = s.jp;
    i_branch   = s.brT; i_jump = s.jpT;
    dm_ack     = 1'($urandom);
    dm_rdata   = $urandom;
    e.regwrite = mis ? 1'b0 : i_regwrite;
    e.memtoreg = i_memtoreg;
    e.memErr   = mis;
    e.regdest  = i_regdest;
    e.aluout   = i_aluout;
    e.pc       = i_pc;
    e.ir       = i_ir;
    e.memdata  = (isMem && !mis && s.rd && !s.wr) ? modelLoad(s.rdat, off, bytes, sgn) : 32'h0;
    e.cyc      = cyc + ((isMem && !mis) ? 1 + s.nAck : 1);
    expQ.push_back(e);
    @(negedge clock);
    chk("redirect", redirect, (s.br && s.zr) || s.jp);
    chk("pc_target", pc_target, s.jp ? s.jpT : s.brT);
    chk("stall_entry", stall, isMem && !mis);
    chk("dm_req_entry", dm_req, 0);
    chk("dm_be_entry", dm_be, 0);
    if (isMem && !mis) begin
      for (int k = 1; k <= s.nAck; k++) begin
        @(posedge clock); #1;
        dm_ack   = (k == s.nAck);
        dm_rdata = (k == s.nAck) ? s.rdat : $urandom;
        @(negedge clock);
        chk("dm_req", dm_req, 1);
        chk("dm_we", dm_we, s.wr);
        chk("dm_addr", dm_addr, s.addr & ~32'h3);
        chk("dm_be", dm_be, expBe);
        if (s.wr) chk("dm_wdata", dm_wdata, modelStore(s.bdat, bytes));
        chk("stall_access", stall, k != s.nAck);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic bubble();
    in_valid  = 1'b0;
    i_memread = 1'($urandom); i_memwrite = 1'($urandom);
    i_branchs = 1'($urandom); i_zero = 1'($urandom); i_jumps = 1'($urandom);
    dm_ack    = 1'($urandom);
    @(negedge clock);
    chk("bubble_redirect", redirect, 0);
    chk("bubble_stall", stall, 0);
    chk("bubble_dm_req", dm_req, 0);
    @(posedge clock); #1;
  endtask

  // Monitor: every presented write-back must match the head of the queue at the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn === 1'b1) begin
        if (wb_valid === 1'b1) begin
          if (expQ.size() == 0) chk("stray_wb_valid", wb_valid, 0);
          else begin
            e = expQ.pop_front();
            chk("wb_cycle", cyc, e.cyc);
            chk("wb_regwrite", wb_regwrite, e.regwrite);
            chk("wb_memtoreg", wb_memtoreg, e.memtoreg);
            chk("wb_regdest", wb_regdest, e.regdest);
            chk("wb_aluout", wb_aluout, e.aluout);
            chk("wb_memdata", wb_memdata, e.memdata);
            chk("wb_pc", wb_pc, e.pc);
            chk("wb_ir", wb_ir, e.ir);
            chk("mem_err", mem_err, e.memErr);
          end
        end else if (mem_err !== 1'b0) begin
          chk("mem_err_without_wb", mem_err, 0);
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [5:0] ldOps[5];
    logic [5:0] stOps[3];
    ldOps = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    stOps = '{6'h28, 6'h29, 6'h2B};
    resetn = 1'b0; in_valid = 1'b0; i_ir = '0; i_pc = '0; i_aluout = '0; i_b = '0;
    i_regdest = '0; i_regwrite = 0; i_memread = 0; i_memwrite = 0; i_memtoreg = 0;
    i_branchs = 0; i_jumps = 0; i_zero = 0; i_branch = '0; i_jump = '0;
    dm_ack = 0; dm_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_wb_memtoreg", wb_memtoreg, 0);
    chk("rst_wb_regdest", wb_regdest, 0);
    chk("rst_wb_aluout", wb_aluout, 0);
    chk("rst_wb_memdata", wb_memdata, 0);
    chk("rst_wb_ir", wb_ir, 0);
    chk("rst_wb_pc", wb_pc, RPC);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_stall", stall, 0);
    @(posedge clock); #1 resetn = 1'b1;

    // Reset while the memory never acknowledges.
    in_valid = 1; i_ir = {6'h23, 26'h0}; i_aluout = 32'h300; i_memread = 1; i_regwrite = 1;
    dm_ack = 0;
    @(negedge clock); chk("mid_stall_entry", stall, 1);
    @(posedge clock); #1;
    @(negedge clock); chk("mid_dm_req", dm_req, 1);
    #2 resetn = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_dm_req_after_rst", dm_req, 0);
    chk("mid_stall_after_rst", stall, 0);
    chk("mid_wb_valid", wb_valid, 0);
    chk("mid_wb_pc", wb_pc, RPC);
    dm_ack = 1'b1;
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock); chk("late_ack_dm_req", dm_req, 0);
    @(posedge clock); #1 dm_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_wb_valid", wb_valid, 0);
    chk("late_ack_stall", stall, 0);
    @(posedge clock); #1;

    // Word load, ack on third access cycle.
    s = blank(); s.op = 6'h23; s.rd = 1; s.addr = 32'h100; s.nAck = 3; s.rdat = 32'hDEADBEEF;
    doInstr(s);
    // Store with same-cycle ack.
    s = blank(); s.op = 6'h2B; s.wr = 1; s.addr = 32'h104; s.bdat = 32'h12345678; s.nAck = 1;
    doInstr(s);
    // Misaligned word load.
    s = blank(); s.op = 6'h23; s.rd = 1; s.addr = 32'h102;
    doInstr(s);
    // Branch, then jump winning over branch.
    s = blank(); s.br = 1; s.zr = 1; s.brT = 32'h40;
    doInstr(s);
    s.jp = 1; s.jpT = 32'h80;
    doInstr(s);
`ifdef DMEM_SUBWORD_EN
    s = blank(); s.op = 6'h20; s.rd = 1; s.addr = 32'h203; s.rdat = 32'h80FF_FF7F; s.nAck = 2;
    doInstr(s);
    s.op = 6'h24;
    doInstr(s);
    s = blank(); s.op = 6'h29; s.wr = 1; s.addr = 32'h206; s.bdat = 32'hCAFE_1234;
    doInstr(s);
`endif
    bubble();

    for (int n = 0; n < 250; n++) begin
      s = blank();
      case ($urandom_range(0, 3))
        0: begin
          s = blank();
        end
        1: begin
          s.br = 1'($urandom); s.zr = 1'($urandom); s.jp = 1'($urandom);
          s.brT = $urandom; s.jpT = $urandom; s.op = 6'($urandom_range(0, 15));
        end
        2: begin
          s.op = ldOps[$urandom_range(0, 4)]; s.rd = 1; s.rdat = $urandom;
          s.addr = $urandom; s.nAck = $urandom_range(1, 4);
          if ($urandom_range(0, 2) != 0) s.addr = s.addr & ~32'h3 | 32'($urandom_range(0, 3) & 2);
        end
        default: begin
          s.op = stOps[$urandom_range(0, 2)]; s.wr = 1; s.bdat = $urandom;
          s.addr = $urandom; s.nAck = $urandom_range(1, 4);
          if ($urandom_range(0, 2) != 0) s.addr = s.addr & ~32'h3 | 32'($urandom_range(0, 3) & 2);
        end
      endcase
      if ($urandom_range(0, 7) == 0) bubble();
      else doInstr(s);
    end

    in_valid = 1'b0; dm_ack = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
